psram_read_cache: RTL and testbench

- Direct-mapped, one-word-per-line, write-through / no-write-allocate cache between the CPU native memory bus and the quad-SPI PSRAM controller.
- Serves repeated reads without an SPI transaction.
- Splits CPU byte-strobe patterns the controller cannot encode into a sequence of legal writes.
- Drives the controller's valid/ready port and obeys its rule that valid drops after ready and stays low until ready falls.

---
 rtl/psram_read_cache.sv | 204 ++++++++++++++++++++
 tb/tb_psram_read_cache.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psram_read_cache.sv
// psram_read_cache
//   Direct-mapped, one-word-per-line, write-through / no-write-allocate cache
//   sitting between the CPU native memory bus and the quad-SPI PSRAM
//   controller. Repeated reads are served from the line array without an
//   SPI transaction. CPU byte-strobe patterns the controller cannot encode
//   are split into at most two legal writes.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   cpu_valid/addr/wdata/wstrb  CPU request (wstrb == 0 means read), held
//                      stable until cpu_ready
//   cpu_ready/rdata    one-cycle completion pulse, read data valid with it
//   flush              one-cycle pulse, invalidate every line
//   mem_valid/addr/wdata/wstrb  request to PSRAM controller
//   mem_ready/rdata    controller done (held until mem_valid falls), data

module psram_read_cache #(
  parameter int INDEX_BITS = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [22:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_wstrb,
  output logic        cpu_ready,
  output logic [31:0] cpu_rdata,
  input  logic        flush,
  output logic        mem_valid,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int TAG_W = 23 - INDEX_BITS;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOOKUP, S_MEM_REQ, S_MEM_RELEASE, S_RESP
  } state_t;

  state_t r_state, w_next;

  // line storage
  logic [DEPTH-1:0]      r_valid;
  logic [TAG_W-1:0]      r_tag  [DEPTH];
  logic [31:0]           r_data [DEPTH];

  // registered array read, taken every IDLE cycle from the live CPU address
  logic                  r_rd_valid;
  logic [TAG_W-1:0]      r_rd_tag;
  logic [31:0]           r_rd_data;

  // control / request state
  logic [INDEX_BITS-1:0] r_sweep;
  logic                  r_flush_pend;
  logic [22:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [3:0]            r_pend;
  logic [31:0]           r_rdata;

  logic [INDEX_BITS-1:0] w_cpu_idx;
  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_W-1:0]      w_tag;
  logic                  w_is_read;
  logic                  w_hit;
  logic                  w_accept;
  logic                  w_lookup_wr;
  logic                  w_fill;
  logic [3:0]            w_chunk;
  logic [31:0]           w_merged;

  assign w_cpu_idx = cpu_addr[INDEX_BITS-1:0];
  assign w_idx     = r_addr[INDEX_BITS-1:0];
  assign w_tag     = r_addr[22:INDEX_BITS];
  assign w_is_read = (r_wstrb == 4'b0000);
  assign w_hit     = r_rd_valid && (r_rd_tag == w_tag);
  assign w_accept  = (r_state == S_IDLE) && (w_next == S_LOOKUP);

  // write hit updates the cached word in place; memory gets it via MEM_REQ
  assign w_lookup_wr = (r_state == S_LOOKUP) && !w_is_read && w_hit;

  // a fill is dropped if a flush was already pending when it returns; a flush
  // landing in the same cycle still lets it write, the sweep removes it later
  assign w_fill = (r_state == S_MEM_REQ) && mem_ready && w_is_read && !r_flush_pend;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_merged[8*b +: 8] = r_wstrb[b] ? r_wdata[8*b +: 8] : r_rd_data[8*b +: 8];
    end
  end

  // Controller accepts only full word, halfword or single byte strobes.
  // Pairs are preferred so any 4-bit mask needs at most two chunks.
  always_comb begin
    if (r_pend == 4'b1111)       w_chunk = 4'b1111;
    else if (r_pend[1:0] == 2'b11) w_chunk = 4'b0011;
    else if (r_pend[3:2] == 2'b11) w_chunk = 4'b1100;
    else                           w_chunk = r_pend & (~r_pend + 4'd1);
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_INIT;
    else         r_state <= w_next;
  end

  // FSM next state and outputs
  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    cpu_rdata = 32'd0;
    mem_valid = 1'b0;
    mem_wstrb = 4'b0000;
    case (r_state)
      S_INIT: begin
        if (&r_sweep) w_next = S_IDLE;
      end
      S_IDLE: begin
        // a pending (or arriving) flush is serviced before any new request
        if (flush || r_flush_pend) w_next = S_INIT;
        else if (cpu_valid)        w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_is_read && w_hit) w_next = S_RESP;
        else                    w_next = S_MEM_REQ;
      end
      S_MEM_REQ: begin
        mem_valid = 1'b1;
        mem_wstrb = w_chunk;
        if (mem_ready) w_next = S_MEM_RELEASE;
      end
      S_MEM_RELEASE: begin
        // controller holds ready until it sees valid low; wait it out
        if (!mem_ready) begin
          if (r_pend != 4'b0000) w_next = S_MEM_REQ;
          else                   w_next = S_RESP;
        end
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = r_rdata;
        w_next    = S_IDLE;
      end
      default: w_next = S_INIT;
    endcase
  end

  // request / control datapath
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sweep      <= '0;
      r_flush_pend <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_pend       <= '0;
      r_rdata      <= '0;
    end else begin
      if ((r_state == S_IDLE) && (w_next == S_INIT)) r_flush_pend <= 1'b0;
      else if (flush)                                 r_flush_pend <= 1'b1;

      // counter wraps back to 0 as the sweep leaves INIT
      if (r_state == S_INIT) r_sweep <= r_sweep + INDEX_BITS'(1);

      if (w_accept) begin
        r_addr  <= cpu_addr;
        r_wdata <= cpu_wdata;
        r_wstrb <= cpu_wstrb;
        r_pend  <= cpu_wstrb;
      end

      if ((r_state == S_LOOKUP) && w_is_read && w_hit) r_rdata <= r_rd_data;

      if ((r_state == S_MEM_REQ) && mem_ready) begin
        r_pend <= r_pend & ~w_chunk;
        if (w_is_read) r_rdata <= mem_rdata;
      end
    end
  end

  // line arrays: no reset, INIT clears the valid bits one per cycle
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE) begin
      r_rd_valid <= r_valid[w_cpu_idx];
      r_rd_tag   <= r_tag[w_cpu_idx];
      r_rd_data  <= r_data[w_cpu_idx];
    end
    if (r_state == S_INIT) r_valid[r_sweep] <= 1'b0;
    if (w_lookup_wr)       r_data[w_idx]    <= w_merged;
    if (w_fill) begin
      r_valid[w_idx] <= 1'b1;
      r_tag[w_idx]   <= w_tag;
      r_data[w_idx]  <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_psram_read_cache.sv
// Bench for psram_read_cache: a PSRAM controller model with random latency
// and ready-hold, a protocol monitor, and a reference model holding the
// golden memory image plus a map of which tag each index currently caches.
module tb_psram_read_cache;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic [22:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psram_read_cache #(.INDEX_BITS(6)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .flush(flush),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // ---------------- PSRAM controller model + protocol monitor ----------------
  typedef struct packed {
    logic [22:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          cyc;
  } req_t;

  logic [31:0] psram [int];
  req_t        reqs[$];
  int          cyc = 0;
  int          valid_rise_cyc = -1;
  int          force_hold = -1;
  int          proto_err = 0;
  logic        prev_valid = 1'b0;
  logic [22:0] hold_addr = '0;
  logic [31:0] hold_wdata = '0;
  logic [3:0]  hold_strb = '0;

  initial begin : ctl
    int wt;
    int hd;
    int a;
    req_t r;
    wt = -1;
    hd = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) begin
        if (mem_valid && !prev_valid) begin
          valid_rise_cyc = cyc;
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
          hold_strb  = mem_wstrb;
          if (mem_ready) proto_err++;          // new request before ready fell
        end
        if (mem_valid && prev_valid &&
            (mem_addr != hold_addr || mem_wdata != hold_wdata || mem_wstrb != hold_strb))
          proto_err++;
        if (mem_valid && !(mem_wstrb inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF}))
          proto_err++;
        if (prev_valid && !mem_valid && !mem_ready) proto_err++;  // dropped before ready
      end
      if (!resetn) begin
        mem_ready = 1'b0;
        wt = -1;
      end else if (mem_ready) begin
        if (!mem_valid) begin
          if (hd > 0) hd--;
          else        mem_ready = 1'b0;
        end
      end else if (mem_valid) begin
        if (wt < 0) wt = int'($urandom_range(0, 3));
        if (wt == 0) begin
          a = int'(mem_addr);
          if (!psram.exists(a)) psram[a] = init_word(a);
          r.addr = mem_addr; r.strb = mem_wstrb; r.wdata = mem_wdata; r.cyc = cyc;
          reqs.push_back(r);
          psram[a]  = merge(psram[a], mem_wdata, mem_wstrb);
          mem_rdata = psram[a];
          mem_ready = 1'b1;
          hd = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
          wt = -1;
        end else begin
          wt--;
        end
      end
      prev_valid = mem_valid;
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] gold [int];
  int          mtag [int];       // index -> tag currently cached
  logic [3:0]  eq[$];

  // legal-chunk sequence for a strobe mask: full word, then halfword pairs,
  // otherwise one byte at a time from the bottom
  task automatic exp_chunks(input logic [3:0] s);
    logic [3:0] p;
    logic [3:0] c;
    eq.delete();
    p = s;
    while (p != 4'h0) begin
      c = 4'h0;
      if (p == 4'hF)           c = 4'hF;
      else if (p[1:0] == 2'b11) c = 4'h3;
      else if (p[3:2] == 2'b11) c = 4'hC;
      else for (int b = 3; b >= 0; b--) if (p[b]) c = 4'(1 << b);
      eq.push_back(c);
      p = p & ~c;
    end
  endtask

  task automatic do_req(input logic [22:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int flush_at, output logic [31:0] rd, output int lat,
                        output logic ok, output logic fl);
    reqs.delete();
    cpu_valid = 1'b1; cpu_addr = a; cpu_wstrb = s; cpu_wdata = d;
    lat = 0; ok = 1'b0; fl = 1'b0; rd = '0;
    while (lat < 3000) begin
      @(negedge clk);
      lat++;
      flush = (lat == flush_at);
      if (flush) fl = 1'b1;
      if (cpu_ready) begin
        rd = cpu_rdata;
        ok = 1'b1;
        break;
      end
    end
    cpu_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic txn(input logic [22:0] a, input logic [3:0] s, input logic [31:0] d,
                     input int flush_at);
    int idx, tg, lat, ai;
    logic hit, ok, fl;
    logic [31:0] exp, rd;
    ai  = int'(a);
    idx = ai % DEPTH;
    tg  = ai / DEPTH;
    hit = mtag.exists(idx) && (mtag[idx] == tg);
    if (!gold.exists(ai)) gold[ai] = init_word(ai);
    gold[ai] = merge(gold[ai], d, s);
    exp = gold[ai];
    do_req(a, s, d, flush_at, rd, lat, ok, fl);
    chk("done", 32'(ok), 32'd1);
    if (s == 4'h0) begin
      chk("rdata", rd, exp);
      if (hit) begin
        chk("hit_nreq", 32'(reqs.size()), 32'd0);
        chk("hit_lat", 32'(lat), 32'd2);
      end else begin
        chk("miss_nreq", 32'(reqs.size()), 32'd1);
        if (reqs.size() > 0) begin
          chk("miss_strb", 32'(reqs[0].strb), 32'd0);
          chk("miss_addr", 32'(reqs[0].addr), 32'(a));
        end
        mtag[idx] = tg;
      end
    end else begin
      exp_chunks(s);
      chk("wr_nreq", 32'(reqs.size()), 32'(eq.size()));
      foreach (eq[i]) begin
        if (i < reqs.size()) begin
          chk("wr_strb", 32'(reqs[i].strb), 32'(eq[i]));
          chk("wr_addr", 32'(reqs[i].addr), 32'(a));
          chk("wr_data", reqs[i].wdata, d);
        end
      end
      chk("wr_mem", psram.exists(ai) ? psram[ai] : 32'hX, exp);
    end
    if (fl) mtag.delete();
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    mtag.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int rst_cyc, t0;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);

    psram[32'h10] = 32'hDEADBEEF;
    gold[32'h10]  = 32'hDEADBEEF;
    resetn  = 1'b1;
    rst_cyc = cyc;
    // request held from the first cycle out of reset: must wait for the sweep
    txn(23'h10, 4'h0, 32'h0, 0);
    chk("init_gap", 32'((valid_rise_cyc - rst_cyc) >= 64), 32'd1);
    txn(23'h10, 4'h0, 32'h0, 0);                 // hit, 2-cycle latency
    txn(23'h10, 4'h6, 32'h11223344, 0);          // split 0010, 0100
    txn(23'h10, 4'h0, 32'h0, 0);
    chk("merged_word", gold[32'h10], 32'hDE2233EF);
    txn(23'h50, 4'h0, 32'h0, 0);                 // same index, other tag
    txn(23'h10, 4'h0, 32'h0, 0);
    txn(23'h20, 4'hF, 32'hCAFEF00D, 0);          // write miss, no allocate
    txn(23'h20, 4'h0, 32'h0, 0);
    txn(23'h10, 4'hB, 32'hA5A55A5A, 0);          // 0011 then 1000

    // flush: next read misses and is issued only after the full sweep
    txn(23'h10, 4'h0, 32'h0, 0);
    t0 = cyc;
    pulse_flush();
    txn(23'h10, 4'h0, 32'h0, 0);
    chk("flush_gap", 32'((valid_rise_cyc - t0) >= 64), 32'd1);

    // flush landing during a read miss: line must not survive
    txn(23'h33, 4'h0, 32'h0, 1);
    txn(23'h33, 4'h0, 32'h0, 0);

    // controller keeps ready high 5 cycles: second chunk must wait for it
    force_hold = 5;
    txn(23'h10, 4'h6, 32'h99887766, 0);
    if (reqs.size() == 2)
      chk("hold_gap", 32'((reqs[1].cyc - reqs[0].cyc) >= 7), 32'd1);
    else
      chk("hold_nreq", 32'(reqs.size()), 32'd2);
    force_hold = -1;

    for (int n = 0; n < 250; n++) begin
      logic [22:0] a;
      logic [3:0]  s;
      int          fa;
      a  = 23'($urandom_range(0, 3) * 64 + $urandom_range(0, 7));
      s  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      fa = ($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 6)) : 0;
      txn(a, s, $urandom, fa);
      if ($urandom_range(0, 29) == 0) pulse_flush();
    end

    chk("protocol", 32'(proto_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
